// File: rtl/comp_weight_loader_pkg.sv
// comp_weight_loader_pkg
//   Shared definitions for the compensation weight loader: FSM state
//   encoding, weight width, default column depth and the parity helper.
package comp_weight_loader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      STREAM,
      DONE
   } state_t;

   localparam int unsigned WEIGHT_W     = 3;
   localparam int unsigned DEFAULT_ROWS = 8;

   // True when a returned memory word (weight plus parity bit) has an odd
   // number of ones, i.e. it breaks even parity.
   function automatic logic odd_ones(input logic [WEIGHT_W:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/comp_weight_loader_if.sv
// comp_weight_loader_if
//   Bundles the loader's control handshake, compensation-memory read bus and
//   CPE-column weight outputs.
//   master : the loader (drives memory reads, weights, status)
//   slave  : the environment (drives start/base_addr/abort, returns mem_rdata)
interface comp_weight_loader_if #(
   parameter int unsigned ADDR_W = 10
);
   import comp_weight_loader_pkg::*;

   logic                start;
   logic [ADDR_W-1:0]   base_addr;
   logic                abort;
   logic                mem_rd_en;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WEIGHT_W:0]   mem_rdata;
   logic [WEIGHT_W-1:0] Compensation_Weight;
   logic                Compensation_Weight_out_valid;
   logic                busy;
   logic                done;
   logic                parity_err;

   modport master (
      input  start, base_addr, abort, mem_rdata,
      output mem_rd_en, mem_addr, Compensation_Weight,
             Compensation_Weight_out_valid, busy, done, parity_err
   );

   modport slave (
      output start, base_addr, abort, mem_rdata,
      input  mem_rd_en, mem_addr, Compensation_Weight,
             Compensation_Weight_out_valid, busy, done, parity_err
   );

endinterface

// File: rtl/comp_weight_loader.sv
// comp_weight_loader
//   Loads one column of ROWS compensation weights from memory and streams
//   them into the CPE column, deepest row first.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - comp_weight_loader_if.master: start/base_addr/abort request,
//            mem_rd_en/mem_addr/mem_rdata read bus, Compensation_Weight and
//            Compensation_Weight_out_valid column feed, busy/done/parity_err
//   Build option: define COMP_LOADER_PARITY_EN to check even parity of every
//   returned word; otherwise mem_rdata[3] is ignored and parity_err is 0.
module comp_weight_loader
   import comp_weight_loader_pkg::*;
#(
   parameter int unsigned ROWS   = DEFAULT_ROWS,
   parameter int unsigned ADDR_W = 10
) (
   input logic                 clk,
   input logic                 rst,
   comp_weight_loader_if.master bus
);

   localparam int unsigned CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [ADDR_W-1:0]   base_q;
   logic                rd_act_q;   // reads still being issued
   logic                ret_q;      // mem_rdata carries a requested word
   logic                valid_q;
   logic [WEIGHT_W-1:0] weight_q;

   logic accept, abort_hit, last_valid;

   assign accept     = (state_q == IDLE) && bus.start && !bus.abort;
   assign abort_hit  = bus.abort && ((state_q == READ) || (state_q == STREAM));
   // Final weight is on the column and nothing remains in the read pipeline.
   assign last_valid = valid_q && !ret_q && !rd_act_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = READ;
         READ:    state_d = abort_hit ? IDLE : STREAM;
         STREAM:  if (abort_hit)       state_d = IDLE;
                  else if (last_valid) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state_q)
         READ, STREAM: bus.busy = 1'b1;
         DONE:         bus.done = 1'b1;
         default:      ;
      endcase
      bus.mem_rd_en = rd_act_q;
      bus.mem_addr  = rd_act_q ? base_q + ADDR_W'(cnt_q) : '0;
   end

   // Read issue and one-cycle-latency return pipeline. Weights are captured
   // only from returned words, so the column value holds while valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         base_q   <= '0;
         rd_act_q <= 1'b0;
         ret_q    <= 1'b0;
         valid_q  <= 1'b0;
         weight_q <= '0;
      end else if (abort_hit) begin
         rd_act_q <= 1'b0;
         ret_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         ret_q   <= rd_act_q;
         valid_q <= ret_q;
         if (ret_q) weight_q <= bus.mem_rdata[WEIGHT_W-1:0];
         if (accept) begin
            base_q   <= bus.base_addr;
            cnt_q    <= CNT_W'(ROWS - 1);
            rd_act_q <= 1'b1;
         end else if (rd_act_q) begin
            if (cnt_q == '0) rd_act_q <= 1'b0;
            else             cnt_q    <= cnt_q - CNT_W'(1);
         end
      end
   end

   assign bus.Compensation_Weight           = weight_q;
   assign bus.Compensation_Weight_out_valid = valid_q;

`ifdef COMP_LOADER_PARITY_EN
   logic perr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                perr_q <= 1'b0;
      else if (ret_q && odd_ones(bus.mem_rdata)) perr_q <= 1'b1;
   end

   assign bus.parity_err = perr_q;
`else
   logic unused_parity_bit;
   assign unused_parity_bit = bus.mem_rdata[WEIGHT_W];
   assign bus.parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_comp_weight_loader.sv
// tb_comp_weight_loader
//   Self-checking bench for comp_weight_loader (ROWS=8, ADDR_W=10). A memory
//   model answers reads one cycle after mem_rd_en; each load is recorded per
//   cycle (cycle 0 = the cycle after the edge that accepts start) and
//   compared against a reference sequence built from the load rules.
//   Honours COMP_LOADER_PARITY_EN for parity expectations.
module tb_comp_weight_loader;

   localparam int ROWS = 8;
   localparam int AW   = 10;
   localparam int NC   = ROWS + 4;

   typedef struct packed {
      logic          rd;
      logic [AW-1:0] addr;
      logic          valid;
      logic [2:0]    w;
      logic          done;
      logic          busy;
      logic          perr;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   comp_weight_loader_if #(.ADDR_W(AW)) bus ();

   comp_weight_loader #(.ROWS(ROWS), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [3:0] mem [0:(1<<AW)-1];
   always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

   obs_t obs_q [0:NC-1];
   obs_t exp_q [0:NC-1];
   logic [2:0] model_w    = '0;
   logic       model_perr = 1'b0;
   int errors = 0;
   int checks = 0;

   function automatic obs_t sample();
      obs_t o;
      o.rd    = bus.mem_rd_en;
      o.addr  = bus.mem_rd_en ? bus.mem_addr : '0;
      o.valid = bus.Compensation_Weight_out_valid;
      o.w     = bus.Compensation_Weight;
      o.done  = bus.done;
      o.busy  = bus.busy;
      o.perr  = bus.parity_err;
      return o;
   endfunction

   task automatic fill_even_random();
      for (int a = 0; a < (1<<AW); a++) begin
         logic [2:0] w;
         w = 3'($urandom_range(0, 7));
         mem[a] = {^w, w};
      end
   endtask

   // Reference: reads go base+ROWS-1 down to base, each word appears as a
   // valid weight two cycles after its read; abort at cycle A kills all
   // activity from cycle A+1, and only a completed load produces done.
   task automatic model_load(input logic [AW-1:0] b, input int abort_at);
      for (int k = 0; k < NC; k++) begin
         obs_t e;
         bit alive;
         alive = (abort_at < 0) || (k <= abort_at);
         e = '0;
         e.rd = alive && (k < ROWS);
         if (e.rd) e.addr = b + AW'(ROWS - 1 - k);
         if (k >= 2 && k - 2 < ROWS && (abort_at < 0 || k - 1 <= abort_at)) begin
            logic [AW-1:0] a;
            logic [3:0]    word;
            a    = b + AW'(ROWS - 1 - (k - 2));
            word = mem[a];
`ifdef COMP_LOADER_PARITY_EN
            if (^word) model_perr = 1'b1;
`endif
            if (alive) model_w = word[2:0];
         end
         e.valid = alive && (k >= 2) && (k <= ROWS + 1);
         e.w     = model_w;
         e.done  = (abort_at < 0) && (k == ROWS + 2);
         e.busy  = alive && (k <= ROWS + 1);
         e.perr  = model_perr;
         exp_q[k] = e;
      end
   endtask

   // Drives one load (start held across one edge) and records NC cycles.
   task automatic launch(input logic [AW-1:0] b, input int abort_at, input bit restart_on_done);
      bus.base_addr = b;
      bus.start     = 1'b1;
      for (int k = 0; k < NC; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (k == abort_at + 1) bus.abort = 1'b0;
         obs_q[k] = sample();
         if (k == abort_at) bus.abort = 1'b1;
         if (restart_on_done && k == ROWS + 2) bus.start = 1'b1;
      end
      bus.abort = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (sample() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", sample(), obs_t'(0));
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      for (int a = 0; a < (1<<AW); a++) begin
         logic [AW-1:0] av;
         av = AW'(a);
         mem[a] = {^av[2:0], av[2:0]};
      end
      model_load(10'd16, -1);
      launch(10'd16, -1, 1'b0);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL nominal cycle %0d got %h expected %h", k, obs_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      model_load(10'd16, -1);
      launch(10'd16, -1, 1'b1);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL b2b_first cycle %0d got %h expected %h", k, obs_q[k], exp_q[k]);
         end
      end
      model_load(10'd16, -1);
      launch(10'd16, -1, 1'b0);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL b2b_second cycle %0d got %h expected %h", k, obs_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_abort();
      model_load(10'd40, 4);
      launch(10'd40, 4, 1'b0);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL abort cycle %0d got %h expected %h", k, obs_q[k], exp_q[k]);
         end
      end
      model_load(10'd77, -1);
      launch(10'd77, -1, 1'b0);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL after_abort cycle %0d got %h expected %h", k, obs_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_wrap();
      model_load(10'd1021, -1);
      launch(10'd1021, -1, 1'b0);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL wrap cycle %0d got %h expected %h", k, obs_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_random();
      fill_even_random();
      for (int n = 0; n < 8; n++) begin
         logic [AW-1:0] b;
         int            ab;
         b  = AW'($urandom);
         ab = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, ROWS + 1));
         model_load(b, ab);
         launch(b, ab, 1'b0);
         for (int k = 0; k < NC; k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
               errors++;
               $display("FAIL random run %0d base %0d abort %0d cycle %0d got %h expected %h",
                        n, b, ab, k, obs_q[k], exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      bus.base_addr = 10'd200;
      bus.start     = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (sample() !== obs_t'(0)) begin
         errors++;
         $display("FAIL async_reset got %h expected %h", sample(), obs_t'(0));
      end
      @(negedge clk);
      rst = 1'b0;
      model_w    = '0;
      model_perr = 1'b0;
      for (int k = 0; k < NC; k++) begin
         @(negedge clk);
         checks++;
         if (sample() !== obs_t'(0)) begin
            errors++;
            $display("FAIL post_reset_idle cycle %0d got %h expected %h", k, sample(), obs_t'(0));
         end
      end
   endtask

   task automatic test_parity();
      fill_even_random();
      mem[100 + ROWS - 1 - 4] = 4'b0001;
      model_load(10'd100, -1);
      launch(10'd100, -1, 1'b0);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL parity cycle %0d got %h expected %h", k, obs_q[k], exp_q[k]);
         end
      end
      repeat (3) @(negedge clk);
      checks++;
`ifdef COMP_LOADER_PARITY_EN
      if (bus.parity_err !== 1'b1) begin
         errors++;
         $display("FAIL parity_sticky got %b expected 1", bus.parity_err);
      end
`else
      if (bus.parity_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_disabled got %b expected 0", bus.parity_err);
      end
`endif
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.base_addr = '0;
      test_reset();
      test_nominal();
      test_back_to_back();
      test_abort();
      test_wrap();
      test_random();
      test_reset_midstream();
      test_parity();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/comp_weight_loader.md
COMP_WEIGHT_LOADER -- requirements
Module: comp_weight_loader

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning number of CPE rows in one compensation column.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning compensation-memory address width.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to load one column.
REQ-006 SHALL have port base_addr  input  ADDR_W  address of row-0 weight; sampled with accepted start.
REQ-007 SHALL have port abort  input  1  cancel an in-progress load.
REQ-008 SHALL have port mem_rd_en  output  1  compensation-memory read strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  compensation-memory read address.
REQ-010 SHALL have port mem_rdata  input  4  read data one cycle after mem_rd_en; [2:0] weight, [3] even-parity bit.
REQ-011 SHALL have port Compensation_Weight  output  3  weight driven into top CPE.
REQ-012 SHALL have port Compensation_Weight_out_valid  output  1  weight shift-enable for the CPE column.
REQ-013 SHALL have port busy  output  1  high from accepted start until done or abort.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last weight is driven.
REQ-015 SHALL have port parity_err  output  1  sticky parity-error flag.

Function
REQ-016 SHALL use FSM states IDLE, READ, STREAM, DONE.
REQ-017 IDLE: start=1 SHALL latch base_addr, load row counter with ROWS-1 and enter READ; start in any other state SHALL be ignored.
REQ-018 READ and STREAM: mem_rd_en SHALL be 1 with mem_addr = base+counter, counter decrementing each cycle; addresses issued SHALL be base+ROWS-1 down to base, exactly ROWS reads (deepest row first so the CPE pass chain ends correctly placed).
REQ-019 READ SHALL last one cycle (memory latency) then enter STREAM.
REQ-020 Each mem_rdata[2:0] SHALL be registered onto Compensation_Weight with Compensation_Weight_out_valid=1 in the cycle after data return; first valid SHALL appear 2 cycles after the start cycle.
REQ-021 Valid SHALL be high for exactly ROWS consecutive cycles, no bubbles; Compensation_Weight SHALL hold last value when valid=0.
REQ-022 After the last valid cycle FSM SHALL enter DONE, pulse done for one cycle, drop busy in the same cycle, return to IDLE.
REQ-023 start coincident with done SHALL be ignored; earliest accepted restart is the cycle after done.
REQ-024 abort=1 in READ/STREAM SHALL, next edge, clear valid, mem_rd_en and busy, enter IDLE, produce no done; abort in IDLE/DONE SHALL have no effect; abort wins over start.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-026 rst SHALL force IDLE, counter 0, mem_rd_en 0, mem_addr 0, Compensation_Weight 0, valid 0, busy 0, done 0, parity_err 0.
REQ-027 rst mid-load SHALL abandon the load with no done pulse.

Configuration
REQ-028 Macro COMP_LOADER_PARITY_EN SHALL enable parity checking.
REQ-029 With it: any returned word whose 4 bits have odd ones-count SHALL set parity_err (cleared only by rst); weight still forwarded.
REQ-030 Without it: mem_rdata[3] ignored, parity_err tied 0.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, the weight width constant (3) and the default ROWS.
REQ-032 Single module; no sub-module.

Verification
REQ-033 ROWS=8, base=16, mem[a]=a[2:0]: start -> addrs 23..16, valid 8 cycles from cycle 2 with weights 7,6,5,4,3,2,1,0, done at cycle 10.
REQ-034 Back-to-back: start again on done cycle ignored; start next cycle accepted, identical sequence.
REQ-035 abort at 3rd valid cycle -> valid 0 next cycle, no done, busy 0, new start works.
REQ-036 base=2^ADDR_W-3, ROWS=8 -> addresses wrap: 4,3,2,1,0,1023,1022,1021 (ADDR_W=10).
REQ-037 PARITY_EN, mem word 4'b0001 at 5th read -> parity_err 1 and stays 1 after done; without macro stays 0.
REQ-038 rst asserted mid-STREAM -> all outputs 0 asynchronously, no done.
